pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
PWM decoder that measures an incoming PWM waveform: high time, period and recovered N-bit duty code. It is the receive-side counterpart of the team's symmetric up/down-counter PWM generator (prescaled clock, high time = DIVISOR*(D+1) clk cycles). It sits at a board-input or loopback point and publishes one measurement per input period with a valid strobe. It also reports loss of activity when the input is stuck.

Parameters:
N, 8, width of recovered duty code DUTY_out
DIVISOR, 2, generator clock prescale; power of two, >=1
CNT_W, 12, width of cycle counters; timeout at 2^CNT_W-1 cycles without a rising edge

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
PWM_in  input  1  asynchronous PWM input
HIGH_out  output  CNT_W  high time of last complete period, clk cycles
PERIOD_out  output  CNT_W  rise-to-rise period of last complete period, clk cycles
DUTY_out  output  N  recovered duty code
VALID_out  output  1  one-cycle strobe: HIGH/PERIOD/DUTY updated
TIMEOUT_out  output  1  level: no rising edge for 2^CNT_W-1 cycles

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all outputs 0, synchronizer flops 0, counters 0, state IDLE.
- Input path: 2-flop synchronizer, then delay flop. s = synchronized level. rise = s & ~s_d. fall = ~s & s_d.
- Latency: PWM_in first sampled high at edge k -> rise true after edge k+1 -> outputs/VALID_out register at edge k+2.
- Counters: per_cnt and high_cnt, saturating at 2^CNT_W-1, never wrapping.
- States: IDLE, MEAS_HIGH, MEAS_LOW.
- IDLE:
  - per_cnt counts every cycle.
  - On rise: per_cnt=1, high_cnt=1, go to MEAS_HIGH. No VALID.
- MEAS_HIGH:
  - per_cnt++ and high_cnt++ each cycle.
  - On fall: go to MEAS_LOW. high_cnt does not count the fall cycle.
- MEAS_LOW:
  - per_cnt++ each cycle.
  - On rise: HIGH_out=high_cnt, PERIOD_out=per_cnt, DUTY_out updated, VALID_out=1 for one cycle, TIMEOUT_out=0, per_cnt=high_cnt=1, go to MEAS_HIGH.
  - The rise cycle counts toward the new period, not the latched one.
  - For an input high H cycles and low L cycles: HIGH_out=H, PERIOD_out=H+L.
- DUTY_out, computed from the latched high_cnt:
  - d = (high_cnt >> log2(DIVISOR)) - 1
  - high_cnt < DIVISOR -> 0
  - d > 2^N-1 -> saturate to 2^N-1
  - Registered on the same edge as HIGH_out.
- Timeout, in any state, when per_cnt reaches 2^CNT_W-1:
  - TIMEOUT_out=1, go to IDLE, no VALID.
  - DUTY_out = s ? all-ones : 0.
  - HIGH_out and PERIOD_out hold their last values.
  - TIMEOUT_out stays 1 until the next VALID.
- After timeout or reset: the first rise only starts a measurement. The first VALID comes on the second rise.
- Simultaneous: rise and saturation in the same cycle -> rise wins (measurement taken with saturated values, TIMEOUT_out cleared).
- Reset mid-operation: immediate return to reset values. A partial period is never reported.
- VALID_out is never asserted on two consecutive cycles. The minimum spacing is 2 cycles (1-cycle high plus 1-cycle low).

Test Plan:
1. Reset: hold rst_n=0 with PWM_in toggling -> all outputs 0. Release with PWM_in=0 -> outputs stay 0, no VALID.
2. Generator pattern, D=100, DIVISOR=2 (high 202, low 312 cycles), 4 periods:
   - no VALID on the first rise;
   - then VALID every 514 cycles with HIGH_out=202, PERIOD_out=514, DUTY_out=100.
3. Extremes:
   - D=0 (high 2, low 512) -> DUTY_out=0, PERIOD_out=514;
   - D=255 (high 512, low 2) -> DUTY_out=255, PERIOD_out=514.
4. Stuck high after a valid measurement, CNT_W=12:
   - 4095 cycles after the last rise -> TIMEOUT_out=1, DUTY_out=255, no VALID;
   - resume D=50 -> first rise no VALID, second rise VALID with DUTY_out=50, TIMEOUT_out=0.
5. Async reset: assert rst_n=0 mid MEAS_LOW, between clock edges -> outputs 0 immediately, before the next edge. After release, the first VALID comes only after two rises.
6. Glitch: 1-cycle high, 9-cycle low, repeated -> HIGH_out=1, PERIOD_out=10, DUTY_out=0 (high_cnt < DIVISOR).

Source files
------------

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and rise-to-rise period of PWM_in and recovers
// the duty code of the matching up/down-counter PWM generator. It also flags a stuck input.
module pwm_capture #(
  parameter int N       = 8,
  parameter int DIVISOR = 2,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PWM_in,
  output logic [CNT_W-1:0] HIGH_out,
  output logic [CNT_W-1:0] PERIOD_out,
  output logic [N-1:0]     DUTY_out,
  output logic             VALID_out,
  output logic             TIMEOUT_out
);

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               SHIFT    = $clog2(DIVISOR);
  localparam int unsigned      DUTY_MAX = (32'd1 << N) - 32'd1;

  logic             sync1, s, s_d;
  logic             rise, fall;
  state_t           state;
  logic [CNT_W-1:0] per_cnt, high_cnt;
  logic [CNT_W-1:0] per_inc, high_inc;
  logic             timeout_hit;

  // Generator high time is DIVISOR*(D+1) cycles, so invert that and clamp to the code range.
  function automatic logic [N-1:0] duty_code(input logic [CNT_W-1:0] h);
    int unsigned q;
    q = 32'(h) >> SHIFT;
    if (32'(h) < 32'(DIVISOR)) return '0;
    if ((q - 32'd1) > DUTY_MAX) return '1;
    return N'(q - 32'd1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= PWM_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  // Once timed out in IDLE the counter sits saturated; the gate keeps the timeout from re-firing there.
  always_comb begin
    rise        = s & ~s_d;
    fall        = ~s & s_d;
    per_inc     = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + 1'b1;
    high_inc    = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + 1'b1;
    timeout_hit = (per_cnt == CNT_MAX) && ((state != IDLE) || !TIMEOUT_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      per_cnt     <= '0;
      high_cnt    <= '0;
      HIGH_out    <= '0;
      PERIOD_out  <= '0;
      DUTY_out    <= '0;
      VALID_out   <= 1'b0;
      TIMEOUT_out <= 1'b0;
    end else begin
      VALID_out <= 1'b0;
      per_cnt   <= per_inc;
      if (rise) begin
        per_cnt  <= CNT_W'(1);
        high_cnt <= CNT_W'(1);
        state    <= MEAS_HIGH;
        if (state == MEAS_LOW) begin
          HIGH_out    <= high_cnt;
          PERIOD_out  <= per_cnt;
          DUTY_out    <= duty_code(high_cnt);
          VALID_out   <= 1'b1;
          TIMEOUT_out <= 1'b0;
        end
      end else if (timeout_hit) begin
        TIMEOUT_out <= 1'b1;
        DUTY_out    <= {N{s}};
        state       <= IDLE;
      end else if (state == MEAS_HIGH) begin
        if (fall) state <= MEAS_LOW;
        else      high_cnt <= high_inc;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: timestamp-based reference model checked every cycle,
// plus hand-computed expectations after each directed scenario.
module tb_pwm_capture;

  localparam int N       = 8;
  localparam int DIVISOR = 2;
  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             PWM_in;
  logic [CNT_W-1:0] HIGH_out;
  logic [CNT_W-1:0] PERIOD_out;
  logic [N-1:0]     DUTY_out;
  logic             VALID_out;
  logic             TIMEOUT_out;

  always #5 clk = ~clk;

  pwm_capture #(.N(N), .DIVISOR(DIVISOR), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .PWM_in(PWM_in),
    .HIGH_out(HIGH_out),
    .PERIOD_out(PERIOD_out),
    .DUTY_out(DUTY_out),
    .VALID_out(VALID_out),
    .TIMEOUT_out(TIMEOUT_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int duty_of(input int h);
    int q;
    if (h < DIVISOR) return 0;
    q = h / DIVISOR - 1;
    if (q > (1 << N) - 1) return (1 << N) - 1;
    return q;
  endfunction

  // Model works on edge timestamps: the DUT reacts at edge e to the input sampled at edge e-2.
  int e = 0, e0 = 1, rise_e = 0, fall_e = 0;
  bit measuring = 0;
  bit h1 = 0, h2 = 0, h3 = 0;
  int m_high = 0, m_per = 0, m_duty = 0;
  bit m_valid = 0, m_to = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e = 0; e0 = 1; rise_e = 0; fall_e = 0; measuring = 0;
      h1 = 0; h2 = 0; h3 = 0;
      m_high = 0; m_per = 0; m_duty = 0; m_valid = 0; m_to = 0;
    end else begin
      e++;
      m_valid = 0;
      if (h2 && !h3) begin
        if (measuring) begin
          m_high  = (fall_e - rise_e > CNT_MAX) ? CNT_MAX : fall_e - rise_e;
          m_per   = (e - rise_e > CNT_MAX) ? CNT_MAX : e - rise_e;
          m_duty  = duty_of(m_high);
          m_valid = 1;
          m_to    = 0;
        end
        measuring = 1;
        rise_e    = e;
        e0        = e;
      end else begin
        if (!h2 && h3) fall_e = e;
        if ((e - e0 >= CNT_MAX) && (measuring || !m_to)) begin
          m_to      = 1;
          m_duty    = h2 ? (1 << N) - 1 : 0;
          measuring = 0;
        end
      end
      h3 = h2;
      h2 = h1;
      h1 = PWM_in;
    end
  end

  int valid_cnt = 0, back2back = 0;
  int last_high = 0, last_per = 0, last_duty = 0;
  bit prev_valid = 0;

  initial forever begin
    @(negedge clk);
    checkOutput("HIGH_out", 32'(HIGH_out), 32'(m_high));
    checkOutput("PERIOD_out", 32'(PERIOD_out), 32'(m_per));
    checkOutput("DUTY_out", 32'(DUTY_out), 32'(m_duty));
    checkOutput("VALID_out", 32'(VALID_out), 32'(m_valid));
    checkOutput("TIMEOUT_out", 32'(TIMEOUT_out), 32'(m_to));
    if (VALID_out === 1'b1) begin
      valid_cnt++;
      last_high = int'(HIGH_out);
      last_per  = int'(PERIOD_out);
      last_duty = int'(DUTY_out);
      if (prev_valid) back2back++;
    end
    prev_valid = (VALID_out === 1'b1);
  end

  task automatic applyStimulus(input logic level, input int cycles);
    PWM_in = level;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic runPeriods(input int hi, input int lo, input int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b1, hi);
      applyStimulus(1'b0, lo);
    end
  endtask

  int v0;

  initial begin
    rst_n  = 1'b0;
    PWM_in = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] reset with toggling input");
    for (int i = 0; i < 6; i++) applyStimulus((i % 2) == 1, 1);
    checkOutput("rst_high", 32'(HIGH_out), 0);
    checkOutput("rst_period", 32'(PERIOD_out), 0);
    checkOutput("rst_duty", 32'(DUTY_out), 0);
    checkOutput("rst_valid", 32'(VALID_out), 0);
    checkOutput("rst_timeout", 32'(TIMEOUT_out), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 10);
    checkOutput("post_rst_valids", valid_cnt, 0);
    checkOutput("post_rst_duty", 32'(DUTY_out), 0);

    $display("[TB] generator D=100");
    v0 = valid_cnt;
    runPeriods(202, 312, 5);
    checkOutput("d100_valids", valid_cnt - v0, 4);
    checkOutput("d100_high", last_high, 202);
    checkOutput("d100_period", last_per, 514);
    checkOutput("d100_duty", last_duty, 100);
    checkOutput("model_d100_high", m_high, 202);
    checkOutput("model_d100_duty", m_duty, 100);

    $display("[TB] generator D=0");
    v0 = valid_cnt;
    runPeriods(2, 512, 3);
    checkOutput("d0_valids", valid_cnt - v0, 3);
    checkOutput("d0_high", last_high, 2);
    checkOutput("d0_period", last_per, 514);
    checkOutput("d0_duty", last_duty, 0);

    $display("[TB] generator D=255");
    v0 = valid_cnt;
    runPeriods(512, 2, 3);
    checkOutput("d255_valids", valid_cnt - v0, 3);
    checkOutput("d255_high", last_high, 512);
    checkOutput("d255_duty", last_duty, 255);
    checkOutput("model_d255_period", m_per, 514);

    $display("[TB] stuck high");
    v0 = valid_cnt;
    applyStimulus(1'b1, 4200);
    checkOutput("stuck_valids", valid_cnt - v0, 1);
    checkOutput("stuck_timeout", 32'(TIMEOUT_out), 1);
    checkOutput("stuck_duty", 32'(DUTY_out), 255);
    checkOutput("stuck_high_hold", 32'(HIGH_out), 512);
    checkOutput("stuck_period_hold", 32'(PERIOD_out), 514);
    checkOutput("model_stuck_timeout", 32'(m_to), 1);
    applyStimulus(1'b0, 412);
    v0 = valid_cnt;
    runPeriods(102, 412, 1);
    checkOutput("resume_first_rise_valids", valid_cnt - v0, 0);
    checkOutput("resume_timeout_held", 32'(TIMEOUT_out), 1);
    runPeriods(102, 412, 1);
    checkOutput("resume_valids", valid_cnt - v0, 1);
    checkOutput("resume_duty", last_duty, 50);
    checkOutput("resume_timeout_clear", 32'(TIMEOUT_out), 0);

    $display("[TB] async reset mid low phase");
    applyStimulus(1'b1, 102);
    applyStimulus(1'b0, 100);
    checkOutput("pre_areset_high", 32'(HIGH_out), 102);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("areset_high", 32'(HIGH_out), 0);
    checkOutput("areset_period", 32'(PERIOD_out), 0);
    checkOutput("areset_duty", 32'(DUTY_out), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    v0 = valid_cnt;
    runPeriods(102, 412, 1);
    checkOutput("areset_first_rise_valids", valid_cnt - v0, 0);
    runPeriods(102, 412, 1);
    checkOutput("areset_valids", valid_cnt - v0, 1);
    checkOutput("areset_duty_after", last_duty, 50);

    $display("[TB] glitch pulses");
    v0 = valid_cnt;
    runPeriods(1, 9, 6);
    checkOutput("glitch_valids", valid_cnt - v0, 6);
    checkOutput("glitch_high", last_high, 1);
    checkOutput("glitch_period", last_per, 10);
    checkOutput("glitch_duty", last_duty, 0);
    v0 = valid_cnt;
    runPeriods(1, 1, 4);
    applyStimulus(1'b0, 5);
    checkOutput("fast_valids", valid_cnt - v0, 4);
    checkOutput("fast_period", last_per, 2);
    checkOutput("valid_back_to_back", back2back, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
